// File: rtl/oflow_score_board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_board_pkg
// Description : Shared types and defaults for the optical-flow score board
//               engine: FSM state encoding, data-width defaults, the match
//               threshold and the score/ID memory address-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package oflow_score_board_pkg;

    localparam int                SCORE_W_DEF   = 16;
    localparam int                ID_LEN_DEF    = 12;
    localparam logic [15:0]       THRESHOLD_DEF = 16'd1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Address into a row-organised buffer: {row, pe}.
    function automatic int addr_w(input int row_len, input int pe_num);
        return row_len + $clog2(pe_num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oflow_score_board_id_alloc.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_board_id_alloc
// Description : Saturating new-object ID allocator. id presents the next
//               free ID; alloc consumes it. The counter starts at 1 (ID 0
//               means "no match"), saturates at all-ones instead of wrapping,
//               and id_overflow latches once an allocation is requested while
//               the counter already sits at all-ones.
// Ports       : clk, reset_N (async, active-low), alloc (in),
//               id (out, ID_LEN), id_overflow (out, sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_score_board_id_alloc
    import oflow_score_board_pkg::*;
#(
    parameter int ID_LEN = ID_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              alloc,
    output logic [ID_LEN-1:0] id,
    output logic              id_overflow
);

    localparam logic [ID_LEN-1:0] c_all_ones = '1;
    localparam logic [ID_LEN-1:0] c_id_one   = ID_LEN'(1);

    logic [ID_LEN-1:0] r_next_id;
    logic              r_overflow;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_next_id  <= c_id_one;
            r_overflow <= 1'b0;
        end else if (alloc) begin
            // Once at all-ones the counter holds, so every later allocation
            // re-issues all-ones and the overflow flag records the loss.
            if (r_next_id == c_all_ones) begin
                r_overflow <= 1'b1;
            end else begin
                r_next_id <= r_next_id + c_id_one;
            end
        end
    end

    assign id          = r_next_id;
    assign id_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/oflow_score_board_engine.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_board_engine
// Description : Responder of the start/done score-board handshake. For each
//               start it reads every valid PE slot of the selected row of
//               the score buffer, decides each object's ID (reuse the
//               matched previous-frame ID or allocate a new one), writes it
//               to the ID memory and pulses done_score_board.
// Ports       : clk, reset_N          - clock, async active-low reset
//               start_score_board     - 1-cycle start (row/frame/num sampled)
//               row_sel_by_set, frame_num, num_valid - job description
//               done_score_board      - 1-cycle completion pulse
//               rd_en/rd_addr, rd_score/rd_id - score buffer read port
//                                       (data returns one cycle after rd_en)
//               wr_en/wr_addr/wr_id   - ID memory write port
//               id_overflow           - sticky new-ID counter saturation
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_score_board_engine
    import oflow_score_board_pkg::*;
#(
    parameter int                 PE_NUM                = 8,
    parameter int                 ROW_LEN               = 4,
    parameter int                 SCORE_W               = SCORE_W_DEF,
    parameter int                 ID_LEN                = ID_LEN_DEF,
    parameter logic [SCORE_W-1:0] THRESHOLD             = SCORE_W'(THRESHOLD_DEF),
    parameter int                 TOTAL_FRAME_NUM_WIDTH = 8,
    localparam int                PE_W                  = $clog2(PE_NUM),
    localparam int                CNT_W                 = PE_W + 1,
    localparam int                ADDR_W                = addr_w(ROW_LEN, PE_NUM)
) (
    input  logic                             clk,
    input  logic                             reset_N,
    input  logic                             start_score_board,
    input  logic [ROW_LEN-1:0]               row_sel_by_set,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num,
    input  logic [CNT_W-1:0]                 num_valid,
    output logic                             done_score_board,
    output logic                             rd_en,
    output logic [ADDR_W-1:0]                rd_addr,
    input  logic [SCORE_W-1:0]               rd_score,
    input  logic [ID_LEN-1:0]                rd_id,
    output logic                             wr_en,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [ID_LEN-1:0]                wr_id,
    output logic                             id_overflow
);

    localparam logic [CNT_W-1:0] c_pe_num  = CNT_W'(PE_NUM);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PE_W-1:0]  c_pe_one  = PE_W'(1);

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [ROW_LEN-1:0]               r_row;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0] r_frame;
    logic [CNT_W-1:0]                 r_num;
    logic [PE_W-1:0]                  r_pe;
    logic                             r_wr_en;
    logic [ADDR_W-1:0]                r_wr_addr;

    logic [CNT_W-1:0]                 w_num_clamped;
    logic                             w_last_rd;
    logic                             w_match;
    logic                             w_alloc;
    logic [ID_LEN-1:0]                w_new_id;

    assign w_num_clamped = (num_valid > c_pe_num) ? c_pe_num : num_valid;
    // Only evaluated in READ, where r_num is at least 1.
    assign w_last_rd     = ({1'b0, r_pe} == (r_num - c_cnt_one));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start outside IDLE (including the DONE cycle) is simply not looked at.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_score_board) begin
                    w_state_nxt = (w_num_clamped == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (w_last_rd) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Job latch, read-address counter and read->write address delay
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_row     <= '0;
            r_frame   <= '0;
            r_num     <= '0;
            r_pe      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            if (r_state == ST_IDLE && start_score_board) begin
                r_row   <= row_sel_by_set;
                r_frame <= frame_num;
                r_num   <= w_num_clamped;
                r_pe    <= '0;
            end else if (r_state == ST_READ) begin
                r_pe <= r_pe + c_pe_one;
            end
            // Write lands in the cycle the read data returns.
            r_wr_en   <= rd_en;
            r_wr_addr <= rd_addr;
        end
    end

    assign rd_en   = (r_state == ST_READ);
    assign rd_addr = rd_en ? {r_row, r_pe} : '0;

    // ------------------------------------------------------------------
    // ID decision on returned data
    // ------------------------------------------------------------------
    assign w_match = (r_frame != '0) && (rd_id != '0) && (rd_score <= THRESHOLD);
    assign w_alloc = r_wr_en && !w_match;

    oflow_score_board_id_alloc #(
        .ID_LEN      (ID_LEN)
    ) u_id_alloc (
        .clk         (clk),
        .reset_N     (reset_N),
        .alloc       (w_alloc),
        .id          (w_new_id),
        .id_overflow (id_overflow)
    );

    assign wr_en            = r_wr_en;
    assign wr_addr          = r_wr_addr;
    assign wr_id            = !r_wr_en ? '0 : (w_match ? rd_id : w_new_id);
    assign done_score_board = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_oflow_score_board_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_oflow_score_board_engine
// Description : Self-checking bench for oflow_score_board_engine: a table of
//               directed rows, randomized rows against a behavioural model,
//               a mid-operation reset and a run to ID saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_score_board_engine;

    localparam int PE_NUM = 8;
    localparam int THR    = 1000;
    localparam int ID_MAX = 4095;

    logic        clk = 1'b0;
    logic        reset_N = 1'b0;
    logic        start_score_board = 1'b0;
    logic [3:0]  row_sel_by_set = '0;
    logic [7:0]  frame_num = '0;
    logic [3:0]  num_valid = '0;
    logic        done_score_board;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] rd_score = '0;
    logic [11:0] rd_id = '0;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [11:0] wr_id;
    logic        id_overflow;

    oflow_score_board_engine dut (
        .clk               (clk),
        .reset_N           (reset_N),
        .start_score_board (start_score_board),
        .row_sel_by_set    (row_sel_by_set),
        .frame_num         (frame_num),
        .num_valid         (num_valid),
        .done_score_board  (done_score_board),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_score          (rd_score),
        .rd_id             (rd_id),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_id             (wr_id),
        .id_overflow       (id_overflow)
    );

    always #5 clk = ~clk;

    // Score buffer: registered read, data valid the cycle after rd_en.
    logic [15:0] mem_score [0:127];
    logic [11:0] mem_id    [0:127];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_score <= mem_score[rd_addr];
            rd_id    <= mem_id[rd_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_next = 1;
    bit m_ovf  = 1'b0;

    task automatic m_decide(input int frame, input int sc, input int id, output int r);
        if (frame != 0 && id != 0 && sc <= THR) begin
            r = id;
        end else begin
            r = m_next;
            if (m_next == ID_MAX) m_ovf = 1'b1;
            else m_next = m_next + 1;
        end
    endtask

    int cap_id [8];
    int cap_done;
    int n_wr;

    // Runs one start/done job; cycle k is counted from the start cycle (k=0).
    task automatic run_row(input int row, input int frame, input int num, input bit extra);
        int n;
        int a;
        int e;
        n = (num > PE_NUM) ? PE_NUM : num;
        cap_done = -1;
        n_wr = 0;
        for (int i = 0; i < 8; i++) cap_id[i] = -1;
        @(negedge clk);
        start_score_board = 1'b1;
        row_sel_by_set    = 4'(row);
        frame_num         = 8'(frame);
        num_valid         = 4'(num);
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            check("overflow", {31'd0, id_overflow}, {31'd0, m_ovf});
            check("rd_en", {31'd0, rd_en}, {31'd0, (k <= n)});
            if (k <= n) check("rd_addr", {25'd0, rd_addr}, row * PE_NUM + k - 1);
            check("wr_en", {31'd0, wr_en}, {31'd0, (k >= 2 && k <= n + 1)});
            if (wr_en) n_wr++;
            if (k >= 2 && k <= n + 1) begin
                a = row * PE_NUM + k - 2;
                check("wr_addr", {25'd0, wr_addr}, a);
                m_decide(frame, int'(mem_score[a]), int'(mem_id[a]), e);
                check("wr_id", {20'd0, wr_id}, e);
                cap_id[k-2] = int'(wr_id);
            end
            check("done", {31'd0, done_score_board}, {31'd0, (k == n + 2)});
            if (done_score_board) cap_done = k;
            start_score_board = extra && (k == 3 || k == n + 2);
        end
        start_score_board = 1'b0;
        check("wr_count", n_wr, n);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0]        row;
        logic [7:0]        frame;
        logic [3:0]        num;
        logic [7:0][15:0]  sc;
        logic [7:0][11:0]  id;
        logic [7:0][11:0]  exp;
        logic [7:0]        exp_done;
    } vec_t;

    vec_t tbl [4];

    task automatic load_row(input int row, input vec_t v);
        for (int i = 0; i < 8; i++) begin
            mem_score[row * PE_NUM + i] = v.sc[i];
            mem_id[row * PE_NUM + i]    = v.id[i];
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        load_row(int'(v.row), v);
        run_row(int'(v.row), int'(v.frame), int'(v.num), 1'b0);
        for (int i = 0; i < int'(v.num); i++)
            check($sformatf("tbl%0d_id%0d", idx, i), cap_id[i], {20'd0, v.exp[i]});
        check($sformatf("tbl%0d_done_cycle", idx), cap_done, {24'd0, v.exp_done});
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_score[i] = '0;
            mem_id[i]    = '0;
        end
        tbl[0] = '0; tbl[1] = '0; tbl[2] = '0; tbl[3] = '0;
        // Row 0, first frame, full row: IDs 1..8, done at cycle 10.
        tbl[0].num = 4'd8; tbl[0].exp_done = 8'd10;
        for (int i = 0; i < 8; i++) begin
            tbl[0].sc[i]  = 16'd5;
            tbl[0].id[i]  = 12'd99;
            tbl[0].exp[i] = 12'(i + 1);
        end
        // Row 1, first frame, 3 objects: IDs 9..11, done at cycle 5.
        tbl[1].row = 4'd1; tbl[1].num = 4'd3; tbl[1].exp_done = 8'd5;
        tbl[1].exp[0] = 12'd9; tbl[1].exp[1] = 12'd10; tbl[1].exp[2] = 12'd11;
        // Later frame: threshold equality matches, 1001 and ID 0 allocate.
        tbl[2].row = 4'd2; tbl[2].frame = 8'd5; tbl[2].num = 4'd4; tbl[2].exp_done = 8'd6;
        tbl[2].sc[0] = 16'd500;  tbl[2].id[0] = 12'd7; tbl[2].exp[0] = 12'd7;
        tbl[2].sc[1] = 16'd1000; tbl[2].id[1] = 12'd2; tbl[2].exp[1] = 12'd2;
        tbl[2].sc[2] = 16'd1001; tbl[2].id[2] = 12'd3; tbl[2].exp[2] = 12'd12;
        tbl[2].sc[3] = 16'd10;   tbl[2].id[3] = 12'd0; tbl[2].exp[3] = 12'd13;
        // Empty row: done at cycle 2.
        tbl[3].row = 4'd3; tbl[3].frame = 8'd5; tbl[3].num = 4'd0; tbl[3].exp_done = 8'd2;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, done_score_board}, 0);
        check("rst_rd_en", {31'd0, rd_en}, 0);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_ovf", {31'd0, id_overflow}, 0);
        check("rst_rd_addr", {25'd0, rd_addr}, 0);
        check("rst_wr_addr", {25'd0, wr_addr}, 0);
        check("rst_wr_id", {20'd0, wr_id}, 0);
        reset_N = 1'b1;

        // ---- directed table ----
        for (int t = 0; t < 4; t++) run_vec(t);

        // ---- extra starts mid-row and in the DONE cycle ----
        for (int i = 0; i < 8; i++) begin
            mem_score[4 * PE_NUM + i] = 16'(100 * i);
            mem_id[4 * PE_NUM + i]    = 12'(i * 3);
        end
        run_row(4, 9, 6, 1'b1);

        // ---- randomized rows ----
        for (int r = 0; r < 40; r++) begin
            int row;
            int frame;
            int num;
            row   = $urandom_range(0, 15);
            frame = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            num   = $urandom_range(0, 15);
            for (int i = 0; i < 8; i++) begin
                mem_score[row * PE_NUM + i] = ($urandom_range(0, 1) == 1) ?
                    16'($urandom_range(990, 1010)) : 16'($urandom);
                mem_id[row * PE_NUM + i] = ($urandom_range(0, 3) == 0) ?
                    12'd0 : 12'($urandom_range(1, 4095));
            end
            run_row(row, frame, num, (num >= 6) && ($urandom_range(0, 1) == 1));
        end

        // ---- reset at cycle 3 of an 8-object row ----
        @(negedge clk);
        start_score_board = 1'b1;
        row_sel_by_set = 4'd0; frame_num = 8'd0; num_valid = 4'd8;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start_score_board = 1'b0;
        end
        check("pre_rst_rd_en", {31'd0, rd_en}, 1);
        check("pre_rst_wr_en", {31'd0, wr_en}, 1);
        reset_N = 1'b0;
        #1;
        check("midrst_rd_en", {31'd0, rd_en}, 0);
        check("midrst_wr_en", {31'd0, wr_en}, 0);
        check("midrst_wr_id", {20'd0, wr_id}, 0);
        m_next = 1;
        m_ovf  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done_score_board}, 0);
            check("midrst_ovf", {31'd0, id_overflow}, 0);
        end
        reset_N = 1'b1;
        run_vec(0);

        // ---- run the allocator into saturation ----
        for (int r = 0; r < 513; r++) run_row(r % 16, 0, 8, 1'b0);
        check("sat_ovf", {31'd0, id_overflow}, 1);
        check("sat_last_id", cap_id[7], ID_MAX);
        run_row(5, 0, 2, 1'b0);
        check("sat_id0", cap_id[0], ID_MAX);
        check("sat_id1", cap_id[1], ID_MAX);
        @(negedge clk);
        check("sat_ovf_sticky", {31'd0, id_overflow}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
